// File: rtl/vga_sync_gen_pkg.sv
// vga_pkg: default 640x480@60 timing constants, total-count helpers and the 10-bit coord_t
package vga_pkg;
  typedef logic [9:0] coord_t;
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster bundle (x, y, bright, hsync, vsync, pixel_en, frame_tick); master drives, slave samples
interface vga_sync_gen_if;
  import vga_pkg::*;
  coord_t x;
  coord_t y;
  logic   bright;
  logic   hsync;
  logic   vsync;
  logic   pixel_en;
  logic   frame_tick;
  modport master (output x, y, bright, hsync, vsync, pixel_en, frame_tick);
  modport slave  (input  x, y, bright, hsync, vsync, pixel_en, frame_tick);
endinterface

// File: rtl/vga_sync_gen_pixel_tick.sv
// vga_pixel_tick: CLK_DIV clock divider; in clk/reset, out registered pixel_en strobe (first high CLK_DIV clks after reset release)
module vga_pixel_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_en
);
  localparam logic [1:0] DIV_MAX = 2'(CLK_DIV - 1);
  logic [1:0] div_cnt_q, div_cnt_d;
  logic       pixel_en_q, pixel_en_d;
  always_comb begin
    div_cnt_d  = reset ? 2'd0 : (div_cnt_q == DIV_MAX ? 2'd0 : div_cnt_q + 2'd1);
    pixel_en_d = !reset && div_cnt_q == DIV_MAX;
  end
  always_ff @(posedge clk) begin
    div_cnt_q  <= div_cnt_d;
    pixel_en_q <= pixel_en_d;
  end
  assign pixel_en = pixel_en_q;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing; in clk/reset, out via vga_sync_gen_if.master (x, y, bright, hsync, vsync, pixel_en, frame_tick); VGA_SYNC_DELAY_EN adds one clk of lag on hsync/vsync
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic              clk,
  input  logic              reset,
  vga_sync_gen_if.master    vga
);
  localparam int     H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int     V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam coord_t X_MAX   = coord_t'(H_TOTAL - 1);
  localparam coord_t Y_MAX   = coord_t'(V_TOTAL - 1);
  localparam coord_t Y_TICK  = coord_t'(V_ACTIVE);
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_cfg
    $error("vga_sync_gen: totals must fit 10 bits and CLK_DIV must be 1..4");
  end
  logic   pixel_en;
  coord_t x_q, x_d, y_q, y_d;
  logic   bright_q, bright_d, hsync_q, hsync_d, vsync_q, vsync_d, frame_tick_q, frame_tick_d;
  vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .reset(reset), .pixel_en(pixel_en));
  always_comb begin
    x_d          = reset ? '0 : !pixel_en ? x_q : x_q == X_MAX ? '0 : x_q + 10'd1;
    y_d          = reset ? '0 : !(pixel_en && x_q == X_MAX) ? y_q : y_q == Y_MAX ? '0 : y_q + 10'd1;
    bright_d     = !reset && int'(x_d) < H_ACTIVE && int'(y_d) < V_ACTIVE;
    hsync_d      = reset || !(int'(x_d) >= H_ACTIVE + H_FP && int'(x_d) < H_ACTIVE + H_FP + H_SYNC);
    vsync_d      = reset || !(int'(y_d) >= V_ACTIVE + V_FP && int'(y_d) < V_ACTIVE + V_FP + V_SYNC);
    frame_tick_d = !reset && pixel_en && x_d == '0 && y_d == Y_TICK;
  end
  always_ff @(posedge clk) begin
    x_q          <= x_d;
    y_q          <= y_d;
    bright_q     <= bright_d;
    hsync_q      <= hsync_d;
    vsync_q      <= vsync_d;
    frame_tick_q <= frame_tick_d;
  end
`ifdef VGA_SYNC_DELAY_EN
  logic hsync_dly_q, hsync_dly_d, vsync_dly_q, vsync_dly_d;
  always_comb begin
    hsync_dly_d = reset || hsync_q;
    vsync_dly_d = reset || vsync_q;
  end
  always_ff @(posedge clk) begin
    hsync_dly_q <= hsync_dly_d;
    vsync_dly_q <= vsync_dly_d;
  end
  assign vga.hsync = hsync_dly_q;
  assign vga.vsync = vsync_dly_q;
`else
  assign vga.hsync = hsync_q;
  assign vga.vsync = vsync_q;
`endif
  assign vga.x          = x_q;
  assign vga.y          = y_q;
  assign vga.bright     = bright_q;
  assign vga.pixel_en   = pixel_en;
  assign vga.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of a shrunken raster (15x11, CLK_DIV 2) and one default 800-pixel line
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_s = 1'b1;
  logic rst_d = 1'b1;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  vga_sync_gen_if vs ();
  vga_sync_gen_if vd ();
  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1)
  ) u_s (.clk(clk), .reset(rst_s), .vga(vs));
  vga_sync_gen u_d (.clk(clk), .reset(rst_d), .vga(vd));
`ifdef VGA_SYNC_DELAY_EN
  localparam int HS_PREV_X = 10;
`else
  localparam int HS_PREV_X = 9;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    int n, k, ticks, vlow, hlow, blt, last, w0, w1;
    logic ph, pv, px_wrap;
    logic [9:0] px;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_x", vs.x, 0);
    chk("rst_y", vs.y, 0);
    chk("rst_bright", vs.bright, 0);
    chk("rst_hsync", vs.hsync, 1);
    chk("rst_vsync", vs.vsync, 1);
    chk("rst_pixel_en", vs.pixel_en, 0);
    chk("rst_frame_tick", vs.frame_tick, 0);
    rst_s = 1'b0;
    @(negedge clk);
    chk("rel1_bright", vs.bright, 1);
    chk("rel1_x", vs.x, 0);
    chk("rel1_y", vs.y, 0);
    chk("rel1_pixel_en", vs.pixel_en, 0);
    @(negedge clk);
    chk("rel2_pixel_en", vs.pixel_en, 1);
    chk("rel2_x", vs.x, 0);
    @(negedge clk);
    chk("rel3_x", vs.x, 1);
    chk("rel3_pixel_en", vs.pixel_en, 0);
    n = 0;
    do begin
      ph = vs.hsync;
      px = vs.x;
      @(negedge clk);
      n++;
    end while (!(ph === 1'b1 && vs.hsync === 1'b0) && n < 100);
    chk("hs_fall_found", n < 100, 1);
    chk("hs_fall_x", vs.x, 10);
    chk("hs_fall_prev_x", px, HS_PREV_X);
    k = 0;
    while (vs.hsync === 1'b0 && k < 50) begin
      k++;
      @(negedge clk);
    end
    chk("hs_low_clks", k, 6);
    ticks = 0;
    vlow = 0;
    last = -1;
    pv = vs.vsync;
    for (int i = 0; i < 660; i++) begin
      if (vs.vsync === 1'b0) vlow++;
      if (pv === 1'b1 && vs.vsync === 1'b0) chk("vs_fall_y", vs.y, 8);
      if (vs.frame_tick === 1'b1) begin
        ticks++;
        chk("tick_x", vs.x, 0);
        chk("tick_y", vs.y, 6);
        chk("tick_bright", vs.bright, 0);
        if (last >= 0) chk("tick_period", i - last, 330);
        last = i;
      end
      pv = vs.vsync;
      @(negedge clk);
    end
    chk("tick_count", ticks, 2);
    chk("vs_low_clks", vlow, 120);
    n = 0;
    while (!(vs.x === 10'd14 && vs.y === 10'd10) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("corner_found", n < 400, 1);
    chk("corner_hsync", vs.hsync, 1);
    chk("corner_vsync", vs.vsync, 1);
    n = 0;
    while (vs.pixel_en !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("wrap_x", vs.x, 0);
    chk("wrap_y", vs.y, 0);
    chk("wrap_bright", vs.bright, 1);
    n = 0;
    while (!(vs.x === 10'd12 && vs.y === 10'd4) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("mid_found", n < 400, 1);
    chk("mid_hsync", vs.hsync, 0);
    rst_s = 1'b1;
    @(negedge clk);
    chk("mid_rst_x", vs.x, 0);
    chk("mid_rst_y", vs.y, 0);
    chk("mid_rst_hsync", vs.hsync, 1);
    chk("mid_rst_bright", vs.bright, 0);
    chk("mid_rst_tick", vs.frame_tick, 0);
    rst_s = 1'b0;
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vs.frame_tick === 1'b1) ticks++;
    end
    chk("mid_no_tick", ticks, 0);
    rst_d = 1'b0;
    @(negedge clk);
    hlow = 0;
    blt = 0;
    w0 = -1;
    w1 = -1;
    ph = vd.hsync;
    px_wrap = 1'b0;
    for (int i = 0; i < 3300; i++) begin
      if (i < 1600 && vd.hsync === 1'b0) hlow++;
      if (i < 1600 && vd.bright === 1'b1) blt++;
      if (ph === 1'b1 && vd.hsync === 1'b0 && i < 1600) chk("d_hs_fall_x", vd.x, 656);
      if (px_wrap && vd.x === 10'd0) begin
        if (w0 < 0) w0 = i;
        else if (w1 < 0) w1 = i;
      end
      px_wrap = (vd.x === 10'd799);
      ph = vd.hsync;
      @(negedge clk);
    end
    chk("d_hs_low_clks", hlow, 192);
    chk("d_bright_clks", blt, 1280);
    chk("d_wraps_seen", (w0 >= 0 && w1 >= 0), 1);
    chk("d_line_period", w1 - w0, 1600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480 @ 60 Hz VGA raster timing from the system clock. It produces the pixel cursor (`x`, `y`), the active-video flag (`bright`) and the active-low `hsync`/`vsync` strobes. It drives the colour-drawing controller, which samples `x`/`y`/`bright` and returns registered RGB. It also emits a once-per-frame tick, in vertical blanking, that the game logic uses to advance plane, mountain and lava positions.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel (50 MHz to 25 MHz); legal range 1..4.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `x` out 10: horizontal counter, 0..H_TOTAL-1.
- `y` out 10: vertical counter, 0..V_TOTAL-1.
- `bright` out 1: high while in the active area.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `pixel_en` out 1: one-clk strobe marking each pixel advance.
- `frame_tick` out 1: one-clk pulse at the start of vertical blanking.

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 800.
  - V_TOTAL = 525.
  - Both must be ≤ 1024 so the counters fit 10 bits; this is checked by elaboration assertion.
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pixel_en` = 1 when `div_cnt` == CLK_DIV-1.
  - With CLK_DIV = 1, `pixel_en` is constant 1 after reset.
- Counters, on `pixel_en`:
  - `x` increments; at H_TOTAL-1 it wraps to 0 and `y` increments.
  - `y` wraps from V_TOTAL-1 to 0 when `x` wraps.
  - Between `pixel_en` strobes all outputs hold.
- Decode:
  - `bright` = (x < H_ACTIVE) && (y < V_ACTIVE).
  - `hsync` = 0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, i.e. x in 656..751.
  - `vsync` = 0 iff y in 490..491.
- Decoded outputs are registered from the next-count values, so they describe the same pixel as the `x`/`y` presented in that cycle.
- `frame_tick`:
  - Asserted for exactly one clk, on the cycle that `x`,`y` become (0, V_ACTIVE).
  - It is never asserted twice within one frame.
- Counter FSM, implicit in the counter values: H_ACTIVE → H_FP → H_SYNC → H_BP per line, and V_ACTIVE → V_FP → V_SYNC → V_BP per frame.

## Timing
- Reset values: `x` = 0, `y` = 0, `div_cnt` = 0, `bright` = 0, `hsync` = 1, `vsync` = 1, `pixel_en` = 0, `frame_tick` = 0.
- `bright` = 0 during reset even though (0,0) is an active pixel. It becomes 1 from the first clk after reset deassertion, with `x` = 0, `y` = 0.
- First `pixel_en`: CLK_DIV clks after reset deasserts; `x` then becomes 1 in the following cycle.
- Line period = H_TOTAL × CLK_DIV clks = 1600.
- Frame period = 800 × 525 × CLK_DIV = 840000 clks.
- Reset asserted mid-frame: all outputs return to reset values on the next clk edge, regardless of `pixel_en`, and no `frame_tick` is emitted.
- Simultaneous x-wrap and y-wrap (x = 799, y = 524): both return to 0 on the same `pixel_en`; `vsync` and `hsync` are both 1 there.

## Configuration
- `VGA_SYNC_DELAY_EN` defined:
  - `hsync` and `vsync` pass through one extra clk register.
  - They then lag `x`/`y`/`bright` by one clk, matching the colour controller's one-clk registered RGB output.
  - The delay registers reset to 1.
- Not defined: `hsync`/`vsync` are aligned with `x`/`y`/`bright` as in Timing.

## Structure
- Shared package `vga_pkg` holds:
  - the default timing constants;
  - derived `H_TOTAL`/`V_TOTAL` functions;
  - the 10-bit coordinate typedef `coord_t`.
- Sub-module `vga_pixel_tick` contains the `CLK_DIV` divider and produces `pixel_en`. All counters and decode stay in `vga_sync_gen`.

## Test plan
- Reset held for 5 clks, then released → all outputs at reset values during reset; `bright` = 1, `x` = 0, `y` = 0 on the first clk after release; `pixel_en` first high 2 clks after release.
- Free-run 1 line at CLK_DIV = 2 → `hsync` low for exactly 192 clks starting when `x` = 656; `bright` high for 1280 clks per line; x-wrap every 1600 clks.
- Free-run 2 frames → `vsync` low for exactly 2 lines (3200 clks) at `y` = 490; `frame_tick` pulses exactly once per 840000 clks, each pulse when `x` = 0, `y` = 480, `bright` = 0.
- Corner wrap: observe `x` = 799, `y` = 524 → next `pixel_en` yields `x` = 0, `y` = 0, `bright` = 1.
- Reset pulsed for 1 clk at `x` = 700, `y` = 300 → next cycle shows `x` = 0, `y` = 0, `hsync` = 1; no spurious `frame_tick`.
- Build with `VGA_SYNC_DELAY_EN` → `hsync` falling edge occurs one clk after `x` first equals 656; without the macro it is the same clk.
